// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - endless-runner game control: state, score, speed ramp, spawn handshake, LFSR
module game_sequencer #(
  parameter int unsigned DX_INIT     = 5,
  parameter int unsigned DX_MAX      = 12,
  parameter int unsigned RAMP_POINTS = 100,
  parameter int unsigned GAP_MIN     = 40,
  parameter int unsigned GAP_MASK    = 63,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        score_tick,
  input  logic        jump,
  input  logic        collide_pix,
  input  logic        spawn_ack,
  output logic [1:0]  game_state,
  output logic [3:0]  dx,
  output logic [13:0] score,
  output logic        spawn_req,
  output logic [1:0]  spawn_type,
  output logic        new_game,
  output logic        freeze
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

  localparam logic [3:0]  DX_INIT_L  = 4'(DX_INIT);
  localparam logic [3:0]  DX_MAX_L   = 4'(DX_MAX);
  localparam logic [15:0] RAMP_L     = 16'(RAMP_POINTS);
  localparam logic [15:0] GAP_MIN_L  = 16'(GAP_MIN);
  localparam logic [15:0] GAP_MASK_L = 16'(GAP_MASK);
  localparam logic [15:0] HOLD_L     = 16'(HOLD_FRAMES);
  localparam logic [13:0] SCORE_MAX  = 14'd9999;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  state_t      state_q, state_d;
  logic [3:0]  dx_q, dx_d;
  logic [13:0] score_q, score_d;
  logic [15:0] ramp_q, ramp_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] lock_q, lock_d;
  logic        flag_q, flag_d;
  logic        req_q, req_d;
  logic [1:0]  type_q, type_d;
  logic        new_q, new_d;
  logic        jump_q;
  logic [15:0] lfsr_q, lfsr_d;

  logic        jump_edge;
  logic        die;
  logic        lfsr_fb;

  // Rising edge of the jump button against its previous-clk value.
  assign jump_edge = jump & ~jump_q;
  // A frame boundary ends the run if any overlap was seen this frame, including right now.
  assign die       = frame_tick & (flag_q | collide_pix);
  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
  assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // Next-state logic for the game FSM and all its counters.
  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    score_d = score_q;
    ramp_d  = ramp_q;
    gap_d   = gap_q;
    lock_d  = lock_q;
    flag_d  = flag_q;
    req_d   = req_q;
    type_d  = type_q;
    new_d   = 1'b0;
    lfsr_d  = {lfsr_fb, lfsr_q[15:1]};

    unique case (state_q)
      ST_IDLE: begin
        dx_d  = 4'd0;
        req_d = 1'b0;
        if (jump_edge) begin
          state_d = ST_RUN;
          new_d   = 1'b1;
          score_d = 14'd0;
          dx_d    = DX_INIT_L;
          gap_d   = GAP_MIN_L;
          flag_d  = 1'b0;
          ramp_d  = 16'd0;
        end
      end

      ST_RUN: begin
        flag_d = flag_q | collide_pix;

        // Only points actually added to the score feed the speed ramp.
        if (score_tick && (score_q != SCORE_MAX)) begin
          score_d = score_q + 14'd1;
          if ((ramp_q + 16'd1) == RAMP_L) begin
            ramp_d = 16'd0;
            dx_d   = (dx_q < DX_MAX_L) ? dx_q + 4'd1 : DX_MAX_L;
          end else begin
            ramp_d = ramp_q + 16'd1;
          end
        end

        if (die) begin
          // Death wins over any spawn activity in the same cycle.
          state_d = ST_DEAD;
          dx_d    = 4'd0;
          req_d   = 1'b0;
          lock_d  = HOLD_L;
        end else if (req_q) begin
          if (spawn_ack) begin
            req_d = 1'b0;
            gap_d = GAP_MIN_L + (lfsr_q & GAP_MASK_L);
          end
        end else if (gap_q == 16'd0) begin
          req_d  = 1'b1;
          type_d = lfsr_q[1:0];
        end else if (frame_tick) begin
          gap_d = gap_q - 16'd1;
        end
      end

      ST_DEAD: begin
        dx_d  = 4'd0;
        req_d = 1'b0;
        if (frame_tick && (lock_q != 16'd0)) begin
          lock_d = lock_q - 16'd1;
        end
        if (jump_edge && (lock_q == 16'd0)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        dx_d    = 4'd0;
        req_d   = 1'b0;
      end
    endcase
  end

  // State register; reset forces an idle, frozen game and a held-high jump history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dx_q    <= 4'd0;
      score_q <= 14'd0;
      ramp_q  <= 16'd0;
      gap_q   <= 16'd0;
      lock_q  <= 16'd0;
      flag_q  <= 1'b0;
      req_q   <= 1'b0;
      type_q  <= 2'd0;
      new_q   <= 1'b0;
      jump_q  <= 1'b1;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      score_q <= score_d;
      ramp_q  <= ramp_d;
      gap_q   <= gap_d;
      lock_q  <= lock_d;
      flag_q  <= flag_d;
      req_q   <= req_d;
      type_q  <= type_d;
      new_q   <= new_d;
      jump_q  <= jump;
      lfsr_q  <= lfsr_d;
    end
  end

  assign game_state = state_q;
  assign dx         = dx_q;
  assign score      = score_q;
  assign spawn_req  = req_q;
  assign spawn_type = type_q;
  assign new_game   = new_q;
  assign freeze     = (state_q != ST_RUN);

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer
module tb_game_sequencer;

  localparam int GAP_MIN  = 40;
  localparam int GAP_MASK = 63;
  localparam int HOLD     = 60;
  localparam int RAMP     = 100;
  localparam int DX_INIT  = 5;
  localparam int DX_MAX   = 12;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        score_tick;
  logic        jump;
  logic        collide_pix;
  logic        spawn_ack;
  logic [1:0]  game_state;
  logic [3:0]  dx;
  logic [13:0] score;
  logic        spawn_req;
  logic [1:0]  spawn_type;
  logic        new_game;
  logic        freeze;

  logic [1:0]  sat_state;
  logic [3:0]  sat_dx;
  logic [13:0] sat_score;
  logic        sat_req;
  logic [1:0]  sat_type;
  logic        sat_new;
  logic        sat_freeze;

  game_sequencer u_dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .score_tick(score_tick),
    .jump(jump), .collide_pix(collide_pix), .spawn_ack(spawn_ack),
    .game_state(game_state), .dx(dx), .score(score), .spawn_req(spawn_req),
    .spawn_type(spawn_type), .new_game(new_game), .freeze(freeze)
  );

  game_sequencer #(.DX_MAX(6)) u_dut_sat (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .score_tick(score_tick),
    .jump(jump), .collide_pix(collide_pix), .spawn_ack(spawn_ack),
    .game_state(sat_state), .dx(sat_dx), .score(sat_score), .spawn_req(sat_req),
    .spawn_type(sat_type), .new_game(sat_new), .freeze(sat_freeze)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit saw_req  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Game model in plain integers: 0 idle, 1 run, 2 dead.
  int m_state, m_dx, m_score, m_ramp, m_gap, m_lock, m_type;
  bit m_flag, m_req, m_new, m_jprev, m_valid;
  int unsigned m_lfsr;

  function automatic int unsigned lfsr_next(input int unsigned v);
    int unsigned b;
    b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return ((v >> 1) | (b << 15)) & 16'hFFFF;
  endfunction

  task automatic model_step();
    bit          edge_j;
    bit          die;
    int unsigned l;
    if (!rst) begin
      m_state = 0; m_dx = 0; m_score = 0; m_ramp = 0; m_gap = 0; m_lock = 0;
      m_type = 0; m_flag = 0; m_req = 0; m_new = 0; m_jprev = 1; m_lfsr = 16'hACE1;
      m_valid = 1;
      return;
    end
    edge_j  = jump && !m_jprev;
    m_jprev = jump;
    l       = m_lfsr;
    m_lfsr  = lfsr_next(m_lfsr);
    m_new   = 0;
    if (m_state == 0) begin
      if (edge_j) begin
        m_state = 1; m_new = 1; m_score = 0; m_dx = DX_INIT; m_gap = GAP_MIN;
        m_flag = 0; m_ramp = 0;
      end
    end else if (m_state == 1) begin
      die    = frame_tick && (m_flag || collide_pix);
      m_flag = m_flag || collide_pix;
      if (score_tick && m_score < 9999) begin
        m_score++;
        m_ramp++;
        if (m_ramp == RAMP) begin
          m_ramp = 0;
          m_dx   = (m_dx + 1 > DX_MAX) ? DX_MAX : m_dx + 1;
        end
      end
      if (die) begin
        m_state = 2; m_dx = 0; m_req = 0; m_lock = HOLD;
      end else if (m_req) begin
        if (spawn_ack) begin
          m_req = 0;
          m_gap = GAP_MIN + int'(l & GAP_MASK);
        end
      end else if (m_gap == 0) begin
        m_req  = 1;
        m_type = int'(l & 3);
      end else if (frame_tick) begin
        m_gap--;
      end
    end else begin
      if (edge_j && m_lock == 0) m_state = 0;
      if (frame_tick && m_lock > 0) m_lock--;
    end
  endtask

  initial begin
    m_valid = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [24:0] act;
    logic [24:0] exp;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        act = {game_state, dx, score, spawn_req, spawn_type, new_game, freeze};
        exp = {2'(m_state), 4'(m_dx), 14'(m_score), m_req, 2'(m_type), m_new, (m_state != 1)};
        check("model_cycle", 32'(act), 32'(exp));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      saw_req |= spawn_req;
    end
  endtask

  task automatic frame_pulse();
    frame_tick = 1'b1; step(1);
    frame_tick = 1'b0; step(1);
  endtask

  task automatic score_pulse();
    score_tick = 1'b1; step(1);
    score_tick = 1'b0; step(1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(game_state), 0);
    check({tag, "_dx"}, 32'(dx), 0);
    check({tag, "_score"}, 32'(score), 0);
    check({tag, "_req"}, 32'(spawn_req), 0);
    check({tag, "_type"}, 32'(spawn_type), 0);
    check({tag, "_new"}, 32'(new_game), 0);
    check({tag, "_freeze"}, 32'(freeze), 1);
  endtask

  initial begin
    int          n;
    int          g2;
    logic [1:0]  t0;
    rst = 1'b0; frame_tick = 1'b0; score_tick = 1'b0; jump = 1'b0;
    collide_pix = 1'b0; spawn_ack = 1'b0;
    step(3);
    check_reset_values("rst0");
    rst = 1'b1;
    step(2);

    // Start of game.
    jump = 1'b1; step(1);
    check("start_state", 32'(game_state), 1);
    check("start_new", 32'(new_game), 1);
    check("start_dx", 32'(dx), 5);
    check("start_score", 32'(score), 0);
    jump = 1'b0; step(1);
    check("start_new_once", 32'(new_game), 0);

    // Speed ramp.
    for (int i = 0; i < 250; i++) score_pulse();
    check("ramp_score", 32'(score), 250);
    check("ramp_dx", 32'(dx), 7);
    check("ramp_dx_sat", 32'(sat_dx), 6);

    // Spawn handshake.
    for (int i = 0; i < 39; i++) frame_pulse();
    check("spawn_early", 32'(spawn_req), 0);
    frame_pulse();
    check("spawn_req", 32'(spawn_req), 1);
    t0 = spawn_type;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("spawn_hold_req", 32'(spawn_req), 1);
      check("spawn_hold_type", 32'(spawn_type), 32'(t0));
    end
    spawn_ack = 1'b1; step(1);
    spawn_ack = 1'b0;
    check("spawn_drop", 32'(spawn_req), 0);
    g2 = m_gap;
    n = 0;
    while (!spawn_req && n < 120) begin
      frame_pulse();
      n++;
    end
    check("gap_range", 32'(n >= 40 && n <= 103), 1);
    check("gap_exact", 32'(n), 32'(g2));

    // Death with the gap expiring on the fatal frame tick.
    spawn_ack = 1'b1; step(1);
    spawn_ack = 1'b0;
    g2 = m_gap;
    saw_req = 1'b0;
    for (int i = 0; i < g2 - 1; i++) frame_pulse();
    collide_pix = 1'b1; step(1);
    collide_pix = 1'b0; step(2);
    frame_tick = 1'b1; step(1);
    frame_tick = 1'b0;
    check("death_state", 32'(game_state), 2);
    check("death_dx", 32'(dx), 0);
    check("death_score", 32'(score), 250);
    step(3);
    check("death_no_spawn", 32'(saw_req), 0);

    // Restart lockout.
    for (int f = 1; f <= 60; f++) begin
      frame_pulse();
      if (f == 10 || f == 59) begin
        jump = 1'b1; step(1);
        check("lock_ignore", 32'(game_state), 2);
        jump = 1'b0; step(1);
      end
    end
    jump = 1'b1; step(1);
    check("unlock_idle", 32'(game_state), 0);
    check("unlock_score", 32'(score), 250);
    jump = 1'b0; step(2);
    jump = 1'b1; step(1);
    check("restart_state", 32'(game_state), 1);
    check("restart_score", 32'(score), 0);
    check("restart_new", 32'(new_game), 1);
    jump = 1'b0; step(1);

    // Reset during a pending spawn.
    for (int i = 0; i < 1234; i++) score_pulse();
    for (int i = 0; i < 40; i++) frame_pulse();
    check("pre_rst_req", 32'(spawn_req), 1);
    check("pre_rst_score", 32'(score), 1234);
    check("pre_rst_dx", 32'(dx), 12);
    jump = 1'b1; step(1);
    rst = 1'b0; step(1);
    check_reset_values("rst1");
    rst = 1'b1;
    saw_req = 1'b0;
    step(5);
    check("post_rst_idle", 32'(game_state), 0);
    check("post_rst_no_req", 32'(saw_req), 0);
    jump = 1'b0; step(2);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
